// File: rtl/vcache_stat_counter_array.sv
// Per-bank saturating vcache event counters with a snapshot shadow bank
// that is drained one word at a time over a valid/yumi stream.
module vcache_stat_counter_array #(
    parameter int num_banks_p     = 4,
    parameter int ctr_width_p     = 32,
    parameter int tag_width_p     = 32,
    parameter int clear_on_snap_p = 0
) (
    input  logic                                        clk_i,
    input  logic                                        reset_n_i,
    input  logic [num_banks_p-1:0]                      req_v_i,
    input  logic [num_banks_p-1:0]                      req_ld_i,
    input  logic [num_banks_p-1:0]                      req_st_i,
    input  logic [num_banks_p-1:0]                      resp_v_i,
    input  logic [num_banks_p-1:0]                      resp_ld_i,
    input  logic [num_banks_p-1:0]                      resp_st_i,
    input  logic [num_banks_p-1:0]                      miss_i,
    input  logic                                        snap_v_i,
    input  logic [tag_width_p-1:0]                      snap_tag_i,
    output logic                                        v_o,
    output logic [ctr_width_p-1:0]                      data_o,
    output logic [((num_banks_p > 1) ? $clog2(num_banks_p) : 1)-1:0] bank_o,
    output logic [2:0]                                  event_o,
    output logic [tag_width_p-1:0]                      tag_o,
    output logic                                        last_o,
    input  logic                                        yumi_i,
    output logic                                        busy_o,
    output logic [7:0]                                  snap_drop_o
);

    localparam int bank_width_lp = (num_banks_p > 1) ? $clog2(num_banks_p) : 1;
    localparam logic [bank_width_lp-1:0] last_bank_lp = bank_width_lp'(num_banks_p - 1);
    localparam logic [2:0] last_event_lp = 3'd6;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e                   state_r, state_n;
    logic [bank_width_lp-1:0] bank_r, bank_n;
    logic [2:0]               event_r, event_n;
    logic [tag_width_p-1:0]   tag_r;
    logic [7:0]               drop_r;

    logic [6:0]             event_v [num_banks_p];
    logic [ctr_width_p-1:0] ctr_r    [num_banks_p][7];
    logic [ctr_width_p-1:0] ctr_n    [num_banks_p][7];
    logic [ctr_width_p-1:0] shadow_r [num_banks_p][7];

    logic snap_accept;
    logic snap_drop;
    logic last_word;

    assign snap_accept = (state_r == IDLE)  && snap_v_i;
    assign snap_drop   = (state_r == DRAIN) && snap_v_i;
    assign last_word   = (bank_r == last_bank_lp) && (event_r == last_event_lp);

    always_comb begin
        for (int unsigned b = 0; b < num_banks_p; b++) begin
            event_v[b] = {
                resp_v_i[b] & resp_st_i[b] & miss_i[b],
                resp_v_i[b] & resp_ld_i[b] & miss_i[b],
                resp_v_i[b] & resp_st_i[b],
                resp_v_i[b] & resp_ld_i[b],
                req_v_i[b]  & req_st_i[b],
                req_v_i[b]  & req_ld_i[b],
                req_v_i[b]
            };
        end
    end

    // Post-update values feed both the live counters and the shadow capture,
    // so events in the snapshot cycle land in the snapshot.
    always_comb begin
        for (int unsigned b = 0; b < num_banks_p; b++) begin
            for (int unsigned e = 0; e < 7; e++) begin
                ctr_n[b][e] = ctr_r[b][e]
                            + ctr_width_p'(event_v[b][e] && (ctr_r[b][e] != '1));
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int unsigned b = 0; b < num_banks_p; b++) begin
                for (int unsigned e = 0; e < 7; e++) begin
                    ctr_r[b][e]    <= '0;
                    shadow_r[b][e] <= '0;
                end
            end
        end else begin
            for (int unsigned b = 0; b < num_banks_p; b++) begin
                for (int unsigned e = 0; e < 7; e++) begin
                    if (snap_accept && (clear_on_snap_p != 0)) begin
                        ctr_r[b][e] <= '0;
                    end else begin
                        ctr_r[b][e] <= ctr_n[b][e];
                    end
                    if (snap_accept) begin
                        shadow_r[b][e] <= ctr_n[b][e];
                    end
                end
            end
        end
    end

    always_comb begin
        state_n = state_r;
        bank_n  = bank_r;
        event_n = event_r;
        case (state_r)
            IDLE: begin
                if (snap_v_i) begin
                    state_n = DRAIN;
                    bank_n  = '0;
                    event_n = '0;
                end
            end
            DRAIN: begin
                if (yumi_i) begin
                    if (last_word) begin
                        state_n = IDLE;
                        bank_n  = '0;
                        event_n = '0;
                    end else if (event_r == last_event_lp) begin
                        bank_n  = bank_r + 1'b1;
                        event_n = '0;
                    end else begin
                        event_n = event_r + 3'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                bank_n  = '0;
                event_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            bank_r  <= '0;
            event_r <= '0;
            tag_r   <= '0;
            drop_r  <= '0;
        end else begin
            state_r <= state_n;
            bank_r  <= bank_n;
            event_r <= event_n;
            if (snap_accept) begin
                tag_r <= snap_tag_i;
            end
            if (snap_drop && (drop_r != 8'hFF)) begin
                drop_r <= drop_r + 8'd1;
            end
        end
    end

    // Every output decodes from registered state only.
    assign v_o         = (state_r == DRAIN);
    assign busy_o      = (state_r == DRAIN);
    assign last_o      = (state_r == DRAIN) && last_word;
    assign data_o      = (state_r == DRAIN) ? shadow_r[bank_r][event_r] : '0;
    assign bank_o      = bank_r;
    assign event_o     = event_r;
    assign tag_o       = tag_r;
    assign snap_drop_o = drop_r;

endmodule

// File: doc/vcache_stat_counter_array.md
# vcache_stat_counter_array

Synthesizable, multi-bank successor to the testbench-only vcache profiler. It keeps seven saturating event counters per vcache bank and, on a snapshot request, freezes all of them into a shadow bank. The frozen values are then drained one word at a time over a valid/yumi stream to a host-readable sink. It sits beside the vcache banks at the manycore edge and observes each bank's incoming-request and outgoing-response handshakes.

## Interface
Parameters:
- num_banks_p, 4, number of vcache banks observed (≥1)
- ctr_width_p, 32, width of each event counter and of data_o (≥2)
- tag_width_p, 32, width of snapshot tag
- clear_on_snap_p, 0, 1 = live counters clear when a snapshot is taken

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  synchronous, active-low reset
- req_v_i  in  num_banks_p  per bank: request accepted (v_i & ready_o)
- req_ld_i  in  num_banks_p  per bank: accepted request is a load
- req_st_i  in  num_banks_p  per bank: accepted request is a store
- resp_v_i  in  num_banks_p  per bank: response handed off (v_o & yumi_i)
- resp_ld_i  in  num_banks_p  per bank: response is for a load
- resp_st_i  in  num_banks_p  per bank: response is for a store
- miss_i  in  num_banks_p  per bank: response went through the miss path
- snap_v_i  in  1  snapshot request, single-cycle pulse
- snap_tag_i  in  tag_width_p  tag latched with the snapshot
- v_o  out  1  stream word valid
- data_o  out  ctr_width_p  counter value
- bank_o  out  max(1,$clog2(num_banks_p))  bank index of the word
- event_o  out  3  event index of the word
- tag_o  out  tag_width_p  latched snapshot tag
- last_o  out  1  final word of the snapshot
- yumi_i  in  1  sink consumes the word (legal only while v_o=1)
- busy_o  out  1  drain in progress
- snap_drop_o  out  8  dropped-snapshot count, saturating

## Operation
- Events per bank b are gated internally as follows:
  - 0 req = req_v_i[b]
  - 1 req_ld = req_v_i[b] & req_ld_i[b]
  - 2 req_st = req_v_i[b] & req_st_i[b]
  - 3 ld = resp_v_i[b] & resp_ld_i[b]
  - 4 st = resp_v_i[b] & resp_st_i[b]
  - 5 ld_miss = event 3 & miss_i[b]
  - 6 st_miss = event 4 & miss_i[b]
- Each counter increments by 1 per cycle its event is high. It saturates at 2^ctr_width_p−1 and does not wrap.
- The FSM has two states:
  - IDLE: busy_o=0, v_o=0. snap_v_i=1 causes the shadow bank to capture every counter's post-update value, so events in the snapshot cycle are included. snap_tag_i is latched to tag_o, the index resets to 0, and the FSM moves to DRAIN.
  - DRAIN: v_o=1, busy_o=1. Words are presented in bank-major order (bank 0 events 0..6, then bank 1, ...), for num_banks_p*7 words in total. yumi_i advances the index. last_o=1 on index num_banks_p*7−1. yumi_i on the last word returns the FSM to IDLE.
- clear_on_snap_p=1: the live counters are 0 in the cycle after capture, and snapshot-cycle events are counted only in the shadow bank. With clear_on_snap_p=0 the counters keep running.
- Live counters keep counting during DRAIN. The shadow bank is unaffected by them.
- A snap_v_i while in DRAIN, including the cycle of the last yumi_i, is dropped. It increments snap_drop_o, which saturates at 255.

## Timing
- Reset (reset_n_i=0 at a clock edge) sets:
  - counters, shadow, snap_drop_o, tag_o and index to 0
  - state to IDLE
  - v_o, busy_o, last_o to 0
  - data_o, bank_o, event_o to 0
- Reset mid-drain aborts the snapshot with no further words.
- An event at cycle t is visible in the counter at t+1.
- snap_v_i at cycle t (IDLE) gives v_o=1 at t+1 with the word for bank 0, event 0.
- With yumi_i held high, one word is delivered per cycle. The snapshot takes num_banks_p*7 cycles, and a new snapshot can be accepted in the cycle after the last yumi_i.
- data_o, bank_o, event_o and last_o are stable while v_o=1 and yumi_i=0.
- The outputs are registered or decoded only from registered state. There are no combinational paths from yumi_i or snap_v_i to any output.

## Test plan
- **Count and drain.** num_banks_p=2. Bank 1 gets 3 load requests, then 2 load responses of which 1 has miss_i=1. Then pulse snap_v_i with tag 0xA5.
  - Expect 14 words.
  - Bank 1 events 0..6 read 3,3,0,2,0,1,0; all of bank 0 reads 0.
  - tag_o=0xA5; last_o only on word 13.
- **Same-cycle capture.** req_v_i[0]=1 in the same cycle as snap_v_i, after 4 prior requests.
  - Bank 0 event 0 reads 5.
  - With clear_on_snap_p=1, a following snapshot with no new traffic reads all 0.
- **Saturation.** ctr_width_p=4, 20 stores on bank 0 -> event 4 reads 15.
- **Backpressure and drops.** Toggle yumi_i 1/0 every cycle during drain.
  - Expect no word skipped or duplicated.
  - Three snap_v_i pulses during DRAIN give snap_drop_o=3 and no extra snapshot.
- **Reset mid-drain.** Deassert reset_n_i (drive low) after word 5.
  - Expect v_o=0 next cycle and all counters 0.
  - A fresh snapshot then reads zeros.
